// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front end: access sizes and controller states.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends a load lane and merges store
// data into an existing memory word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = word_i[{off_i, 3'b000} +: 8];
    half_v  = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{signed_i & byte_v[7]}}, byte_v};
        merge_o = word_i;
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{16{signed_i & half_v[15]}}, half_v};
        merge_o = word_i;
        merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-addressed load/store front end for a word-only memory; sub-word stores
// are done as read-modify-write, one request outstanding at a time.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_memW,
  output logic        mem_memR,
  input  logic [31:0] mem_readData
);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic        ld_req;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept  = req_valid && ready_q;
  assign req_err = (req_size == SZ_ILL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || ({2'b00, req_addr[31:2]} > 32'(SIZE - 1));

  mem_lane_align u_align (
    .word_i   (mem_readData),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merge_o  (merge_val)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ld_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ld_req  = 1'b1;
          addr_d  = {2'b00, req_addr[31:2]};
          rdata_d = '0;
          err_d   = req_err;
          if (req_we) data_d = req_wdata;
          if (req_err)                           state_d = RESP;
          else if (req_we && req_size == SZ_WORD) state_d = WR;
          else                                    state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          data_d  = merge_val;
          state_d = WR;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WR:   state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // ready is registered so it stays low while reset is held and for no longer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_req) begin
      we_q     <= req_we;
      size_q   <= req_size;
      signed_q <= req_signed;
      off_q    <= req_addr[1:0];
      wdata_q  <= req_wdata;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_memR    = (state_q == RD);
  assign mem_memW    = (state_q == WR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 1-cycle-latency word memory model.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_memW;
  logic        mem_memR;
  logic [31:0] mem_readData;

  logic [31:0] mem [0:31];
  logic [31:0] rd_q;
  logic [31:0] last_wa, last_wd;
  int          n_rd = 0, n_wr = 0, n_both = 0;
  int          errors = 0, checks = 0;

  mem_access_ctrl #(.SIZE(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_memW     (mem_memW),
    .mem_memR     (mem_memR),
    .mem_readData (mem_readData)
  );

  always #5 clk = ~clk;

  assign mem_readData = rd_q;

  always @(posedge clk) begin
    if (mem_memR) begin
      rd_q <= mem[mem_address[4:0]];
      n_rd <= n_rd + 1;
    end
    if (mem_memW) begin
      mem[mem_address[4:0]] <= mem_data;
      last_wa <= mem_address;
      last_wd <= mem_data;
      n_wr    <= n_wr + 1;
    end
    if (mem_memR && mem_memW) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // Full transaction: accept, wait for response, check latency/data/strobes, handshake.
  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_r, input int exp_w);
    int r0, w0, lat;
    @(negedge clk);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    r0 = n_rd;
    w0 = n_wr;
    drive(we, sz, sgn, addr, wdata);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, ".n_memR"}, 32'(n_rd - r0), 32'(exp_r));
    check({tag, ".n_memW"}, 32'(n_wr - w0), 32'(exp_w));
  endtask

  initial begin
    int lat;
    int w0, r0;

    repeat (3) @(negedge clk);
    check("rst.req_ready", {31'd0, req_ready}, 32'd0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst.strobes", {30'd0, mem_memR, mem_memW}, 32'd0);
    check("rst.mem_address", mem_address, 32'd0);
    check("rst.mem_data", mem_data, 32'd0);
    reset = 1'b1;
    #1 check("rel.req_ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("rel.req_ready_after_edge", {31'd0, req_ready}, 32'd1);

    xact("wst", 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
    check("wst.mem2", mem[2], 32'hDEADBEEF);
    check("wst.addr", last_wa, 32'd2);
    check("wst.data", last_wd, 32'hDEADBEEF);

    xact("lb_s_B", 1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 1, 0);
    xact("lh_u_8", 1'b0, SZ_HALF, 1'b0, 32'h8, 32'h0, 3, 32'h0000BEEF, 1'b0, 1, 0);
    xact("lh_s_8", 1'b0, SZ_HALF, 1'b1, 32'h8, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 1, 0);
    xact("lh_s_A", 1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0, 3, 32'hFFFFDEAD, 1'b0, 1, 0);
    xact("lb_u_9", 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 3, 32'h000000BE, 1'b0, 1, 0);
    xact("lw_8", 1'b0, SZ_WORD, 1'b1, 32'h8, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1, 0);

    xact("sb_9", 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'hFFFFFF55, 4, 32'h0, 1'b0, 1, 1);
    check("sb_9.mem2", mem[2], 32'hDEAD55EF);
    check("sb_9.data", last_wd, 32'hDEAD55EF);
    xact("sh_A", 1'b1, SZ_HALF, 1'b0, 32'hA, 32'hABCD1234, 4, 32'h0, 1'b0, 1, 1);
    check("sh_A.mem2", mem[2], 32'h123455EF);

    xact("sw_7C", 1'b1, SZ_WORD, 1'b0, 32'h7C, 32'hA5A50F0F, 2, 32'h0, 1'b0, 0, 1);
    check("sw_7C.addr", last_wa, 32'd31);
    xact("lb_s_7D", 1'b0, SZ_BYTE, 1'b1, 32'h7D, 32'h0, 3, 32'h0000000F, 1'b0, 1, 0);
    xact("lh_s_7E", 1'b0, SZ_HALF, 1'b1, 32'h7E, 32'h0, 3, 32'hFFFFA5A5, 1'b0, 1, 0);

    xact("err_h3", 1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    xact("err_w2", 1'b1, SZ_WORD, 1'b0, 32'h2, 32'h1, 1, 32'h0, 1'b1, 0, 0);
    xact("err_sz3", 1'b0, SZ_ILL, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    xact("err_oor", 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    xact("err_sb_oor", 1'b1, SZ_BYTE, 1'b0, 32'h81, 32'h0, 1, 32'h0, 1'b1, 0, 0);

    // Response backpressure with a competing request held on the input.
    @(negedge clk);
    drive(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check("bp.latency", 32'(lat), 32'd3);
    r0 = n_rd;
    w0 = n_wr;
    drive(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h11111111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp.rsp_rdata", rsp_rdata, 32'h123455EF);
      check("bp.req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    check("bp.no_memR", 32'(n_rd - r0), 32'd0);
    check("bp.no_memW", 32'(n_wr - w0), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp.rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    check("bp.req_ready_after", {31'd0, req_ready}, 32'd1);
    check("bp.mem2", mem[2], 32'h123455EF);

    // rsp_ready asserted before the response exists.
    rsp_ready = 1'b1;
    drive(1'b0, SZ_ILL, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("early.rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("early.rsp_err", {31'd0, rsp_err}, 32'd1);
    @(posedge clk);
    #1;
    check("early.rsp_valid_gone", {31'd0, rsp_valid}, 32'd0);
    check("early.req_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b0;

    // Reset pulsed during the WR cycle of a byte store.
    @(negedge clk);
    w0 = n_wr;
    drive(1'b1, SZ_BYTE, 1'b0, 32'h8, 32'h00000077);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstwr.memW_before", {31'd0, mem_memW}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rstwr.memW_dropped", {31'd0, mem_memW}, 32'd0);
    check("rstwr.memR", {31'd0, mem_memR}, 32'd0);
    check("rstwr.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstwr.req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rstwr.no_write", 32'(n_wr - w0), 32'd0);
    check("rstwr.mem2", mem[2], 32'h123455EF);
    @(negedge clk);
    check("rstwr.idle_ready", {31'd0, req_ready}, 32'd1);
    check("rstwr.idle_rsp", {31'd0, rsp_valid}, 32'd0);
    xact("rstwr.lw_8", 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 3, 32'h123455EF, 1'b0, 1, 0);

    check("strobe_overlap", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store front end sitting directly upstream of the word-addressed data memory. Accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. Drives the memory's word-only write/read strobes, performing read-modify-write for sub-word stores. Returns extended load data or an error over a valid/ready response channel.

## Interface
- SIZE, 32, number of 32-bit words in the downstream memory; legal word index 0..SIZE-1
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 halfword, 2 word, 3 illegal
- req_signed  input  1  sign-extend loads (ignored for word loads and for stores)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned, illegal size or out-of-range request
- mem_address  output  32  word index = req_addr[31:2]
- mem_data  output  32  write word
- mem_memW  output  1  memory write strobe
- mem_memR  output  1  memory read strobe
- mem_readData  input  32  memory read word, valid the cycle after mem_memR is sampled

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- In IDLE, req_ready=1. A request is accepted when req_valid&&req_ready. On acceptance it is registered whole; no other state reads the req_* inputs.
- Error check at acceptance:
  - size 3
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] > SIZE-1
- An errored request goes IDLE->RESP with rsp_err=1 and rsp_rdata=0. No memory strobe is raised.
- Load: IDLE->RD->CAP->RESP.
- Word store: IDLE->WR->RESP.
- Byte/halfword store: IDLE->RD->CAP->WR->RESP.
- RD: mem_memR=1 for exactly one cycle.
- CAP: the block registers mem_readData.
  - Loads: extract the lane and extend it into rsp_rdata.
  - Stores: merge the new bytes into the word.
- WR: mem_memW=1 for exactly one cycle, with mem_data holding the full or merged word.
- Lane rules, little-endian:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Loads zero-extend, or sign-extend from bit 7/15 when req_signed=1.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready. On rsp_valid&&rsp_ready the block returns to IDLE. A store with no error has rsp_err=0 and rsp_rdata=0.
- mem_memW and mem_memR are never 1 together. Both are 0 outside RD/WR. mem_address holds the registered word index from acceptance until RESP exits.

## Timing
- Request accepted at edge E0. rsp_valid rises after:
  - E1 for an error
  - E2 for a word store
  - E3 for a load
  - E4 for a sub-word store
- req_ready=0 from E0 until the response handshake edge. This gives one outstanding request and no overlap.
- Memory read latency is a fixed 1 cycle. No timeout exists.
- Reset values, applied asynchronously on reset=0:
  - state IDLE
  - rsp_valid 0, rsp_rdata 0, rsp_err 0
  - mem_memR 0, mem_memW 0, mem_address 0, mem_data 0
  - req_ready 0 while reset=0, 1 from the first edge after release
- Reset during RD, CAP or WR drops the strobes immediately. No partial store is committed. A pending response is discarded.
- rsp_ready may be held high in advance. The handshake then completes on the first edge with rsp_valid=1.

## Structure
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
  - the state enum (IDLE, RD, CAP, WR, RESP)
- Sub-module mem_lane_align (combinational) takes word, offset, size and signed.
  - Produces the extended load value.
  - Produces the merged store word from old word + new data.

## Test plan
- Word store 0xDEADBEEF to addr 0x8 -> exactly one mem_memW cycle with mem_address=2 and mem_data=0xDEADBEEF. rsp_valid 2 cycles after accept, rsp_err=0.
- Memory word 2 = 0xDEADBEEF; signed byte load at addr 0xB -> rsp_rdata=0xFFFFFFDE. Unsigned halfword load at 0x8 -> rsp_rdata=0x0000BEEF. Each rsp_valid is 3 cycles after accept.
- Byte store 0x55 to addr 0x9 over 0xDEADBEEF -> one mem_memR cycle, then one mem_memW cycle with mem_data=0xDEAD55EF. rsp_valid 4 cycles after accept.
- Halfword at 0x3, word at 0x2, size 3, word load at 0x80 with SIZE=32 -> each gives rsp_err=1 and rsp_rdata=0. No memory strobe for any of them. rsp_valid 1 cycle after accept.
- rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, and a second req_valid is not accepted.
- reset pulsed low during the WR state of a byte store -> mem_memW falls immediately. The memory word is unchanged and state is IDLE.
